// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the seven-segment scan controller.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seg_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [7:0] SEG_OFF = 8'h00;

  // Hex glyphs 0..F (lower-case b and d keep them distinct from 8 and 0)
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// hex7seg: combinational nibble to seven-segment decoder.
module hex7seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan of NDIG seven-segment digits over one
// segment bus, with a valid/ready shadow register committed at frame boundaries.
// Optional build macro LEADING_ZERO_BLANK_EN: leading zero digits (dp clear,
// never digit 0) stay dark during their drive window.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int SLOT_CYC  = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                ld_valid,
  input  logic [4*NDIG-1:0]   ld_data,
  input  logic [NDIG-1:0]     ld_dp,
  output logic                ld_ready,
  output logic [7:0]          seg,
  output logic [NDIG-1:0]     an,
  output logic                frame_done
);

  localparam int CNT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  scan_state_t         r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DIG_W-1:0]    r_dig;
  logic [4*NDIG-1:0]   r_disp;
  logic [NDIG-1:0]     r_disp_dp;
  logic [4*NDIG-1:0]   r_shadow;
  logic [NDIG-1:0]     r_shadow_dp;
  logic                r_pending;
  logic                r_ld_ready;
  logic [7:0]          r_seg;
  logic [NDIG-1:0]     r_an;
  logic                r_frame_done;

  logic                w_accept;
  logic                w_slot_end;
  logic                w_last_dig;
  logic                w_commit;
  logic [3:0]          w_nibble;
  logic [6:0]          w_seg7;
  logic                w_dp;
  logic                w_suppress;

  assign w_accept   = ld_valid && r_ld_ready;
  assign w_slot_end = (r_cnt == CNT_W'(SLOT_CYC - 1));
  assign w_last_dig = (r_dig == DIG_W'(NDIG - 1));
  assign w_commit   = en && (r_state == DRIVE) && w_slot_end && w_last_dig && r_pending;
  assign w_nibble   = r_disp[r_dig*4 +: 4];
  assign w_dp       = r_disp_dp[r_dig];

  hex7seg u_hex7seg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg7)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic w_upper_zero;

  // Current digit and everything to its left are zero nibbles
  always_comb begin
    w_upper_zero = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if ((i >= int'(r_dig)) && (r_disp[i*4 +: 4] != 4'h0)) w_upper_zero = 1'b0;
    end
  end

  assign w_suppress = (r_dig != '0) && w_upper_zero && !w_dp;
`else
  assign w_suppress = 1'b0;
`endif

  // Slot timing FSM with registered segment/anode outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= BLANK;
      r_cnt        <= '0;
      r_dig        <= '0;
      r_seg        <= SEG_OFF;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (en) begin
        case (r_state)
          BLANK: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(BLANK_CYC - 1)) begin
              r_state <= DRIVE;
              if (w_suppress) begin
                r_an  <= '1;
                r_seg <= SEG_OFF;
              end else begin
                r_an  <= ~(NDIG'(1) << r_dig);
                r_seg <= {w_dp, w_seg7};
              end
            end
          end
          DRIVE: begin
            if (w_slot_end) begin
              r_state      <= BLANK;
              r_cnt        <= '0;
              r_dig        <= w_last_dig ? '0 : r_dig + 1'b1;
              r_an         <= '1;
              r_seg        <= SEG_OFF;
              r_frame_done <= w_last_dig;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= BLANK;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Load handshake into the shadow and commit to the display at frame end.
  // Accept and commit are exclusive: accept needs pending low, commit needs it high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp      <= '0;
      r_disp_dp   <= '0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_pending   <= 1'b0;
      r_ld_ready  <= 1'b1;
    end else if (w_commit) begin
      r_disp     <= r_shadow;
      r_disp_dp  <= r_shadow_dp;
      r_pending  <= 1'b0;
      r_ld_ready <= 1'b1;
    end else if (w_accept) begin
      r_shadow    <= ld_data;
      r_shadow_dp <= ld_dp;
      r_pending   <= 1'b1;
      r_ld_ready  <= 1'b0;
    end
  end

  assign ld_ready   = r_ld_ready;
  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed plus randomized checking of seg_scan_ctrl against
// a position-based display model (NDIG=4, SLOT_CYC=8, BLANK_CYC=2).
module tb_seg_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int SLOT  = 8;
  localparam int BLNK  = 2;
  localparam int FRAME = NDIG * SLOT;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic [3:0]  ld_dp;
  logic        ld_ready;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  seg_scan_ctrl #(.NDIG(NDIG), .SLOT_CYC(SLOT), .BLANK_CYC(BLNK)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_dp      (ld_dp),
    .ld_ready   (ld_ready),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [6:0] glyph [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Model: p = enabled clock edges since reset; the display position follows from it.
  int          p;
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_dp, m_sdp;
  bit          m_pend, m_fd, m_acc;

  task automatic model_edge();
    bit acc;
    if (reset) begin
      p = 0; m_disp = '0; m_dp = '0; m_shadow = '0; m_sdp = '0;
      m_pend = 0; m_fd = 0; m_acc = 0;
    end else begin
      acc = ld_valid && !m_pend;
      m_fd = 0;
      if (en) begin
        p++;
        if (p % FRAME == 0) begin
          m_fd = 1;
          if (m_pend) begin
            m_disp = m_shadow; m_dp = m_sdp; m_pend = 0;
          end
        end
      end
      if (acc) begin
        m_shadow = ld_data; m_sdp = ld_dp; m_pend = 1;
      end
      m_acc = acc;
    end
  endtask

  task automatic check_outputs();
    int          phase, d;
    logic [7:0]  e_seg;
    logic [3:0]  e_an;
    bit          dark;
    phase = p % SLOT;
    d     = (p / SLOT) % NDIG;
    e_seg = 8'h00;
    e_an  = 4'hF;
    if (phase >= BLNK) begin
      dark = 0;
`ifdef LEADING_ZERO_BLANK_EN
      dark = (d != 0) && ((m_disp >> (4*d)) == 16'h0) && !m_dp[d];
`endif
      if (!dark) begin
        e_an  = ~(4'b0001 << d);
        e_seg = {m_dp[d], glyph[(m_disp >> (4*d)) & 16'hF]};
      end
    end
    checks++;
    assert (seg === e_seg) else begin
      errors++; $error("FAIL seg p=%0d: got %h want %h", p, seg, e_seg);
    end
    checks++;
    assert (an === e_an) else begin
      errors++; $error("FAIL an p=%0d: got %h want %h", p, an, e_an);
    end
    checks++;
    assert (frame_done === m_fd) else begin
      errors++; $error("FAIL frame_done p=%0d: got %b want %b", p, frame_done, m_fd);
    end
    checks++;
    assert (ld_ready === !m_pend) else begin
      errors++; $error("FAIL ld_ready p=%0d: got %b want %b", p, ld_ready, !m_pend);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Hold a request until the model sees it accepted, then drop valid
  task automatic load(input logic [15:0] data, input logic [3:0] dp);
    ld_valid = 1'b1; ld_data = data; ld_dp = dp;
    for (int i = 0; i < 4 * FRAME; i++) begin
      step();
      if (m_acc) break;
    end
    ld_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_dp = '0;
    p = 0; m_disp = '0; m_dp = '0; m_shadow = '0; m_sdp = '0;
    m_pend = 0; m_fd = 0; m_acc = 0;

    // Reset and free-running scan of zeros
    steps(3);
    reset = 1'b0;
    steps(2 * FRAME + 5);

    // Load 1234, shown from the frame after the next boundary
    load(16'h1234, 4'h0);
    steps(2 * FRAME);

    // Second request while pending waits for the commit
    load(16'h1111, 4'h0);
    load(16'hABCD, 4'h0);
    steps(2 * FRAME);

    // Freeze mid-drive on digit 2
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((p / SLOT) % NDIG == 2 && p % SLOT == 4) break;
      step();
    end
    en = 1'b0;
    steps(10);
    en = 1'b1;
    steps(FRAME + 4);

    // Reset mid-drive with a pending shadow
    load(16'h5678, 4'h5);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_pend && p % SLOT >= BLNK) break;
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    steps(2 * FRAME);

    // Leading zero cases and decimal points
    load(16'h0050, 4'h0);
    steps(2 * FRAME);
    load(16'h0000, 4'h0);
    steps(2 * FRAME);
    load(16'h0007, 4'h4);
    steps(2 * FRAME);

    // Randomized traffic with enable gaps and an occasional reset
    for (int i = 0; i < 1500; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      ld_valid = ($urandom_range(0, 3) == 0);
      ld_data  = 16'($urandom);
      ld_dp    = 4'($urandom);
      reset    = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0; ld_valid = 1'b0; en = 1'b1;
    steps(FRAME);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
